instruction_memory_pipelined: RTL and testbench

- Parametrised, clocked successor to the combinational instruction ROM.
- Word-addressed instruction store with a valid/ready fetch port and a 1-cycle registered read.
- Adds a program-load write port and fault reporting for misaligned or out-of-range fetches.
- Sits between the fetch/PC stage and the decode stage; the testbench or boot logic fills it through the load port.

---
 rtl/instruction_memory_pipelined.sv | 120 ++++++++++++
 tb/tb_instruction_memory_pipelined.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_pipelined.sv
// Word-addressed instruction store: valid/ready fetch port, registered read, load port.
// Optional IMEM_FETCH_COUNT_EN adds a saturating fetch_count output.
module instruction_memory_pipelined #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int BYTE_OFF   = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_fault,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
`ifdef IMEM_FETCH_COUNT_EN
  output logic [31:0]           fetch_count,
`endif
  output logic                  ld_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((64'd1 << BYTE_OFF) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_fault_q, resp_fault_d;
  logic                  ld_err_q, ld_err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] req_word, ld_word;
  logic [IDX_W-1:0]      req_idx, ld_idx;
  logic                  req_ok, ld_ok;
  logic                  accept;

  // Full-width range compare so high address bits never alias into the array.
  assign req_word = req_addr >> BYTE_OFF;
  assign ld_word  = ld_addr >> BYTE_OFF;
  assign req_idx  = req_word[IDX_W-1:0];
  assign ld_idx   = ld_word[IDX_W-1:0];
  assign req_ok   = ((req_addr & OFF_MASK) == '0) && (req_word < DEPTH_W);
  assign ld_ok    = ((ld_addr & OFF_MASK) == '0) && (ld_word < DEPTH_W);

  assign req_ready = !ld_en && ((state_q == EMPTY) || resp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    ld_err_d     = ld_en && !ld_ok;
    if (accept) begin
      state_d      = FULL;
      resp_data_d  = req_ok ? mem_q[req_idx] : '0;
      resp_fault_d = !req_ok;
    end else if ((state_q == FULL) && resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= EMPTY;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
      ld_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      ld_err_q     <= ld_err_d;
    end
  end

  // Program image is kept across reset.
  always_ff @(posedge CLK) begin
    if (ld_en && ld_ok) begin
      mem_q[ld_idx] <= ld_data;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;
  assign ld_err     = ld_err_q;

`ifdef IMEM_FETCH_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Directed bench for instruction_memory_pipelined.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_instruction_memory_pipelined;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        ld_en;
  logic [63:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_err;
`ifdef IMEM_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  instruction_memory_pipelined dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
`ifdef IMEM_FETCH_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .ld_err     (ld_err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Single fetch with resp_ready=1; checks the response one edge later.
  task automatic fetch(input string tag, input logic [63:0] a,
                       input logic [31:0] d, input logic f);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = a;
    tick();
    req_valid = 1'b0;
    check({tag, "_v"}, 64'(resp_valid), 64'd1);
    check({tag, "_d"}, 64'(resp_data), 64'(d));
    check({tag, "_f"}, 64'(resp_fault), 64'(f));
    tick();
  endtask

  logic [63:0] b2b_a [3] = '{64'h0, 64'h4, 64'h8};
  logic [31:0] b2b_d [3] = '{32'hF84003E9, 32'hAA0B014A, 32'h17FFFFFD};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    #3;
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_data", 64'(resp_data), 64'd0);
    check("rst_fault", 64'(resp_fault), 64'd0);
    check("rst_lderr", 64'(ld_err), 64'd0);
    tick();
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) load(b2b_a[i], b2b_d[i]);
    check("ld_ok_err", 64'(ld_err), 64'd0);
    load(64'hFC, 32'h12345678);

    resp_ready = 1'b1;
    req_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = b2b_a[i];
      #1;
      check("b2b_rdy", 64'(req_ready), 64'd1);
      @(posedge CLK);
      #1;
      check("b2b_v", 64'(resp_valid), 64'd1);
      check("b2b_d", 64'(resp_data), 64'(b2b_d[i]));
      check("b2b_f", 64'(resp_fault), 64'd0);
    end
    req_valid = 1'b0;
    tick();
    check("b2b_empty", 64'(resp_valid), 64'd0);

    fetch("mis", 64'h6, 32'h0, 1'b1);
    fetch("oor", 64'h100, 32'h0, 1'b1);
    fetch("hiaddr", 64'h1_0000_0000, 32'h0, 1'b1);
    fetch("last", 64'hFC, 32'h12345678, 1'b0);

    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 64'h4;
    tick();
    req_addr = 64'h8;
    for (int i = 0; i < 3; i++) begin
      check("stl_v", 64'(resp_valid), 64'd1);
      check("stl_d", 64'(resp_data), 64'hAA0B014A);
      check("stl_rdy", 64'(req_ready), 64'd0);
      tick();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #1;
    check("stl_rel_rdy", 64'(req_ready), 64'd1);
    tick();
    check("stl_done", 64'(resp_valid), 64'd0);
    check("stl_rdy1", 64'(req_ready), 64'd1);

    req_valid = 1'b1;
    req_addr  = 64'h4;
    ld_en     = 1'b1;
    ld_addr   = 64'h4;
    ld_data   = 32'hD2E24689;
    #1;
    check("ldpri_rdy", 64'(req_ready), 64'd0);
    tick();
    ld_en = 1'b0;
    check("ldpri_noacc", 64'(resp_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    check("raw_v", 64'(resp_valid), 64'd1);
    check("raw_d", 64'(resp_data), 64'hD2E24689);
    tick();

    load(64'h102, 32'hDEADBEEF);
    check("lderr_hi", 64'(ld_err), 64'd1);
    tick();
    check("lderr_lo", 64'(ld_err), 64'd0);
    load(64'h100, 32'hCAFEF00D);
    check("lderr_oor", 64'(ld_err), 64'd1);
    tick();
    fetch("oor2", 64'h100, 32'h0, 1'b1);

    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 64'h8;
    tick();
    req_valid = 1'b0;
    check("pre_rst_d", 64'(resp_data), 64'h17FFFFFD);
    Reset = 1'b1;
    #1;
    check("arst_v", 64'(resp_valid), 64'd0);
    check("arst_d", 64'(resp_data), 64'd0);
`ifdef IMEM_FETCH_COUNT_EN
    check("arst_cnt", 64'(fetch_count), 64'd0);
`endif
    tick();
    Reset = 1'b0;
    tick();
    fetch("post_rst", 64'h0, 32'hF84003E9, 1'b0);
`ifdef IMEM_FETCH_COUNT_EN
    check("cnt1", 64'(fetch_count), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
